// File: rtl/cpu_alu_pkg.sv
// Shared ALU opcodes, flag bit positions and arbiter FSM state encoding.
package cpu_alu_pkg;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_XOR = 5'b00100;
  localparam logic [4:0] ALU_SLT = 5'b00110;
  localparam logic [4:0] ALU_SLL = 5'b00111;
  localparam logic [4:0] ALU_ROR = 5'b11001;

  localparam int unsigned FLG_C = 0;
  localparam int unsigned FLG_Z = 1;
  localparam int unsigned FLG_V = 2;
  localparam int unsigned FLG_N = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_rr_arbiter_cpu_alu.sv
// Combinational ALU: add/sub/logic/set-less-than and single-bit shift/rotate.
module Cpu_Alu
  import cpu_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEL_WIDTH  = 5
) (
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [SEL_WIDTH-1:0]  ALU_Sel,
  output logic [DATA_WIDTH-1:0] ALU_Out,
  output logic                  CarryOut,
  output logic                  Zero,
  output logic                  Overflow,
  output logic                  Negative
);

  localparam int unsigned MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, A} + {1'b0, B};
    diff     = {1'b0, A} - {1'b0, B};
    ALU_Out  = '0;
    CarryOut = 1'b0;
    Overflow = 1'b0;
    case (ALU_Sel)
      ALU_ADD: begin
        ALU_Out  = sum[MSB:0];
        CarryOut = sum[DATA_WIDTH];
        Overflow = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
      end
      ALU_SUB: begin
        // CarryOut reports a borrow on subtraction.
        ALU_Out  = diff[MSB:0];
        CarryOut = diff[DATA_WIDTH];
        Overflow = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
      end
      ALU_AND: ALU_Out = A & B;
      ALU_OR:  ALU_Out = A | B;
      ALU_XOR: ALU_Out = A ^ B;
      ALU_SLT: ALU_Out[0] = $signed(A) < $signed(B);
      ALU_SLL: begin
        ALU_Out  = {A[MSB-1:0], 1'b0};
        CarryOut = A[MSB];
      end
      ALU_ROR: begin
        ALU_Out  = {A[0], A[MSB:1]};
        CarryOut = A[0];
      end
      default: ALU_Out = '0;
    endcase
    Zero     = (ALU_Out == '0);
    Negative = ALU_Out[MSB];
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-port round-robin front end for one shared Cpu_Alu; one operation in flight.
module alu_rr_arbiter
  import cpu_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEL_WIDTH  = 5,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [SEL_WIDTH-1:0]  req0_sel,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [SEL_WIDTH-1:0]  req1_sel,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_out,
  output logic [3:0]            rsp_flags,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  ops_done
);

  logic [1:0]            state;
  logic                  ptr;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [SEL_WIDTH-1:0]  op_sel;
  logic                  op_id;

  logic                  win;
  logic                  grant;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  alu_c, alu_z, alu_v, alu_n;
  logic [3:0]            alu_flags;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    win   = (req0_valid && req1_valid) ? ptr : req1_valid;
    grant = (state == ST_IDLE) && (req0_valid || req1_valid);
  end

  assign req0_ready = grant && !win;
  assign req1_ready = grant && win;
  assign busy       = (state != ST_IDLE);

  always_comb begin
    alu_flags        = '0;
    alu_flags[FLG_C] = alu_c;
    alu_flags[FLG_Z] = alu_z;
    alu_flags[FLG_V] = alu_v;
    alu_flags[FLG_N] = alu_n;
  end

  Cpu_Alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_alu (
    .A        (op_a),
    .B        (op_b),
    .ALU_Sel  (op_sel),
    .ALU_Out  (alu_out),
    .CarryOut (alu_c),
    .Zero     (alu_z),
    .Overflow (alu_v),
    .Negative (alu_n)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_sel    <= '0;
      op_id     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_out   <= '0;
      rsp_flags <= '0;
      ops_done  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            op_a   <= win ? req1_a   : req0_a;
            op_b   <= win ? req1_b   : req0_b;
            op_sel <= win ? req1_sel : req0_sel;
            op_id  <= win;
            ptr    <= ~win;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_out   <= alu_out;
          rsp_flags <= alu_flags;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + CNT_WIDTH'(1);
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
